// File: rtl/gate_truth_checker_if.sv
// -----------------------------------------------------------------------------
// gate_truth_checker_if
//   Bundles the stimulus/response and status signals of gate_truth_checker.
//   master : the environment. Drives start and the gate outputs obs, and
//            observes the stimulus and status.
//   slave  : the checker. Drives the stimulus a/b and all status outputs.
// Signals
//   start     run request (honoured only while the checker is idle)
//   a, b      stimulus to the gate inputs
//   obs[5:0]  gate outputs [0]AND [1]OR [2]XOR [3]NAND [4]NOR [5]XNOR
//   busy      run in progress
//   done      one-cycle end-of-run pulse
//   pass      run finished with zero mismatching bits
//   err_mask  sticky per-output mismatch mask
//   err_count saturating count of mismatching bits
//   fail_vec  {a,b} of the first failing sample
//   fail_obs  obs captured at the first failing sample
// -----------------------------------------------------------------------------
interface gate_truth_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic [5:0] obs;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] err_mask;
    logic [7:0] err_count;
    logic [1:0] fail_vec;
    logic [5:0] fail_obs;

    modport master (
        output start, obs,
        input  a, b, busy, done, pass, err_mask, err_count, fail_vec, fail_obs
    );

    modport slave (
        input  start, obs,
        output a, b, busy, done, pass, err_mask, err_count, fail_vec, fail_obs
    );
endinterface

// File: rtl/gate_truth_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_checker
//   Clocked stimulus/response engine for the two-input gate set. Walks {a,b}
//   through 00,01,10,11 for PASSES sweeps, holds each vector SETTLE_CYCLES
//   cycles, then samples obs and compares it to the ideal truth table.
//   Accumulates a sticky mismatch mask and a saturating mismatch-bit count,
//   and reports pass/done at the end of the run.
// Parameters
//   SETTLE_CYCLES  hold cycles before each sample (1..255)
//   PASSES         full truth-table sweeps per run (1..65535)
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   chk_if  slave side of gate_truth_checker_if (start/obs in, rest out)
// Configuration
//   GATE_CHK_FAILCAP_EN : when defined, the first failing {a,b} and its obs
//                         are captured into fail_vec/fail_obs; otherwise
//                         those outputs are tied to zero.
// -----------------------------------------------------------------------------
module gate_truth_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_truth_checker_if.slave  chk_if
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] PASS_LAST   = 16'(PASSES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  vec_q;
    logic [7:0]  settle_cnt_q;
    logic [15:0] pass_cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [5:0]  err_mask_q;
    logic [7:0]  err_count_q;

    logic [5:0]  err_mask_d;
    logic [7:0]  err_count_d;
    logic [5:0]  mismatch;
    logic        last_sample;
    logic        accept;

    // Ideal gate outputs for vector {a,b}, in obs bit order.
    function automatic logic [5:0] expected_obs(input logic [1:0] v);
        logic va;
        logic vb;
        va = v[1];
        vb = v[0];
        return {~(va ^ vb), ~(va | vb), ~(va & vb), va ^ vb, va | vb, va & vb};
    endfunction

    function automatic logic [2:0] popcount6(input logic [5:0] x);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, x[i]};
        end
        return n;
    endfunction

    // Saturating accumulate: once 255 is reached the count stays there.
    function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [2:0] inc);
        logic [8:0] sum;
        sum = {1'b0, acc} + {6'b000000, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // Per-sample compare and next error state; only committed in SAMPLE.
    always_comb begin
        mismatch    = chk_if.obs ^ expected_obs(vec_q);
        err_mask_d  = err_mask_q | mismatch;
        err_count_d = sat_add(err_count_q, popcount6(mismatch));
        last_sample = (vec_q == 2'd3) && (pass_cnt_q == PASS_LAST);
        accept      = (state_q == ST_IDLE) && chk_if.start;
    end

    // Run sequencer with registered stimulus and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= 2'd0;
            settle_cnt_q <= 8'd0;
            pass_cnt_q   <= 16'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_mask_q   <= 6'd0;
            err_count_q  <= 8'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        vec_q        <= 2'd0;
                        settle_cnt_q <= 8'd0;
                        pass_cnt_q   <= 16'd0;
                        err_mask_q   <= 6'd0;
                        err_count_q  <= 8'd0;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_q <= 8'd0;
                        state_q      <= ST_SAMPLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    err_mask_q  <= err_mask_d;
                    err_count_q <= err_count_d;
                    if (last_sample) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_d == 8'd0);
                        state_q <= ST_DONE;
                    end else begin
                        // Vector 3 wraps to 0 and begins the next sweep.
                        vec_q <= vec_q + 2'd1;
                        if (vec_q == 2'd3) begin
                            pass_cnt_q <= pass_cnt_q + 16'd1;
                        end
                        state_q <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign chk_if.a         = vec_q[1];
    assign chk_if.b         = vec_q[0];
    assign chk_if.busy      = busy_q;
    assign chk_if.done      = done_q;
    assign chk_if.pass      = pass_q;
    assign chk_if.err_mask  = err_mask_q;
    assign chk_if.err_count = err_count_q;

`ifdef GATE_CHK_FAILCAP_EN
    logic [1:0] fail_vec_q;
    logic [5:0] fail_obs_q;

    // First-failure capture; an empty err_mask means no earlier failure this run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vec_q <= 2'd0;
            fail_obs_q <= 6'd0;
        end else if (accept) begin
            fail_vec_q <= 2'd0;
            fail_obs_q <= 6'd0;
        end else if ((state_q == ST_SAMPLE) && (mismatch != 6'd0) && (err_mask_q == 6'd0)) begin
            fail_vec_q <= vec_q;
            fail_obs_q <= chk_if.obs;
        end else begin
            fail_vec_q <= fail_vec_q;
            fail_obs_q <= fail_obs_q;
        end
    end

    assign chk_if.fail_vec = fail_vec_q;
    assign chk_if.fail_obs = fail_obs_q;
`else
    assign chk_if.fail_vec = 2'd0;
    assign chk_if.fail_obs = 6'd0;
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_truth_checker
//   Directed bench for gate_truth_checker. A gate model with selectable faults
//   drives obs. A run-level model predicts every output from the run schedule
//   (start edge, settle length, number of completed samples) and is compared
//   against the main instance every cycle; literal expectations pin key results.
//   A second instance with PASSES=100 covers saturation and long latency.
// -----------------------------------------------------------------------------
module tb_gate_truth_checker;

    localparam int S  = 2;
    localparam int S1 = S + 1;
    localparam int L  = 4 * S1;          // main instance run length, PASSES=1
    localparam int LONG_P = 100;

    logic clk;
    logic rst_n;
    int   fault_main;
    int   fault_long;
    int   cyc_free;
    int   n_checks;
    int   n_pass;
    bit   cmp_en;

    gate_truth_checker_if main_if ();
    gate_truth_checker_if long_if ();

    gate_truth_checker #(.SETTLE_CYCLES(S), .PASSES(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .chk_if (main_if.slave)
    );

    gate_truth_checker #(.SETTLE_CYCLES(S), .PASSES(LONG_P)) dut_long (
        .clk    (clk),
        .rst_n  (rst_n),
        .chk_if (long_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_free = 0;
    always @(posedge clk) cyc_free <= cyc_free + 1;

    // Ideal gate outputs by arithmetic: [0]AND [1]OR [2]XOR [3]NAND [4]NOR [5]XNOR
    function automatic logic [5:0] truth(input int ai, input int bi);
        logic [5:0] t;
        t[0] = (ai * bi) == 1;
        t[1] = (ai + bi) > 0;
        t[2] = (ai + bi) == 1;
        t[3] = !t[0];
        t[4] = !t[1];
        t[5] = !t[2];
        return t;
    endfunction

    // Gates under test: 0 good, 1 XOR stuck 0, 2 NAND/NOR swapped, 3 all inverted
    function automatic logic [5:0] gate_obs(input int fault, input int ai, input int bi);
        logic [5:0] r;
        logic [5:0] t;
        t = truth(ai, bi);
        r = t;
        case (fault)
            1: r[2] = 1'b0;
            2: begin r[3] = t[4]; r[4] = t[3]; end
            3: r = ~t;
            default: r = t;
        endcase
        return r;
    endfunction

    always_comb main_if.obs = gate_obs(fault_main, int'(main_if.a), int'(main_if.b));
    always_comb long_if.obs = gate_obs(fault_long, int'(long_if.a), int'(long_if.b));

    // Result after k completed samples: {count[21:14], mask[13:8], fvec[7:6], fobs[5:0]}
    function automatic logic [21:0] run_summary(input int fault, input int k);
        int         cnt;
        logic [5:0] mask;
        logic [1:0] fvec;
        logic [5:0] fobs;
        logic [5:0] mm;
        logic [5:0] got;
        bit         seen;
        cnt = 0; mask = 6'd0; fvec = 2'd0; fobs = 6'd0; seen = 1'b0;
        for (int n = 0; n < k; n++) begin
            got = gate_obs(fault, (n % 4) / 2, n % 2);
            mm  = got ^ truth((n % 4) / 2, n % 2);
            if (mm != 6'd0 && !seen) begin
                seen = 1'b1;
                fvec = 2'(n % 4);
                fobs = got;
            end
            mask = mask | mm;
            cnt  = cnt + $countones(mm);
            if (cnt > 255) cnt = 255;
        end
        return {8'(cnt), mask, fvec, fobs};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Run-level model: which edge accepted the current run and with which gates.
    int  ec;
    int  p0;
    bit  have_run;
    int  run_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ec       <= 0;
            p0       <= 0;
            have_run <= 1'b0;
            run_fault <= 0;
        end else begin
            ec <= ec + 1;
            // Idle once a previous run is at least one cycle past its done cycle.
            if (main_if.start && (!have_run || (ec - p0) >= L + 1)) begin
                p0        <= ec + 1;
                have_run  <= 1'b1;
                run_fault <= fault_main;
            end
        end
    end

    int          m_d;
    int          m_k;
    logic [21:0] m_sum;
    logic [1:0]  e_vec;
    logic        e_busy, e_done, e_pass;

    // Every-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            if (!have_run) begin
                e_vec = 2'd0; e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
                m_sum = 22'd0;
            end else begin
                m_d    = ec - p0;
                m_k    = (m_d < L) ? m_d / S1 : 4;
                m_sum  = run_summary(run_fault, m_k);
                e_vec  = (m_d < L) ? 2'((m_d / S1) % 4) : 2'd3;
                e_busy = m_d < L;
                e_done = m_d == L;
                e_pass = (m_d >= L) && (m_sum[21:14] == 8'd0);
            end
`ifndef GATE_CHK_FAILCAP_EN
            m_sum[7:0] = 8'd0;
`endif
            chk("m_ab",        32'({main_if.a, main_if.b}), 32'(e_vec));
            chk("m_busy",      32'(main_if.busy),      32'(e_busy));
            chk("m_done",      32'(main_if.done),      32'(e_done));
            chk("m_pass",      32'(main_if.pass),      32'(e_pass));
            chk("m_err_count", 32'(main_if.err_count), 32'(m_sum[21:14]));
            chk("m_err_mask",  32'(main_if.err_mask),  32'(m_sum[13:8]));
            chk("m_fail_vec",  32'(main_if.fail_vec),  32'(m_sum[7:6]));
            chk("m_fail_obs",  32'(main_if.fail_obs),  32'(m_sum[5:0]));
        end
    end

    task automatic start_main(output int t);
        @(negedge clk);
        main_if.start = 1'b1;
        t = cyc_free;
        @(negedge clk);
        main_if.start = 1'b0;
    endtask

    task automatic wait_done_main(input int t, input int exp_lat);
        int lat;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (main_if.done) begin
                lat = cyc_free - t;
                break;
            end
        end
        chk("main_done_latency", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int t;
        int lat;
        n_checks = 0;
        n_pass   = 0;
        cmp_en   = 1'b0;
        fault_main = 0;
        fault_long = 3;
        main_if.start = 1'b0;
        long_if.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ab",    32'({main_if.a, main_if.b}), 32'd0);
        chk("rst_busy",  32'(main_if.busy), 32'd0);
        chk("rst_pass",  32'(main_if.pass), 32'd0);
        chk("rst_count", 32'(main_if.err_count), 32'd0);
        cmp_en = 1'b1;

        // 1: correct gates
        fault_main = 0;
        start_main(t);
        chk("t1_busy_first", 32'(main_if.busy), 32'd1);
        wait_done_main(t, 13);
        chk("t1_pass",  32'(main_if.pass), 32'd1);
        chk("t1_mask",  32'(main_if.err_mask), 32'd0);
        chk("t1_count", 32'(main_if.err_count), 32'd0);

        // 2: XOR stuck at 0
        fault_main = 1;
        start_main(t);
        wait_done_main(t, 13);
        chk("t2_mask",  32'(main_if.err_mask), 32'h04);
        chk("t2_count", 32'(main_if.err_count), 32'd2);
        chk("t2_pass",  32'(main_if.pass), 32'd0);
`ifdef GATE_CHK_FAILCAP_EN
        chk("t2_fail_vec", 32'(main_if.fail_vec), 32'h1);
        chk("t2_fail_obs", 32'(main_if.fail_obs), 32'h0A);
`else
        chk("t2_fail_vec", 32'(main_if.fail_vec), 32'h0);
        chk("t2_fail_obs", 32'(main_if.fail_obs), 32'h00);
`endif

        // 3: NAND/NOR swapped
        fault_main = 2;
        start_main(t);
        wait_done_main(t, 13);
        chk("t3_mask",  32'(main_if.err_mask), 32'h18);
        chk("t3_count", 32'(main_if.err_count), 32'd4);

        // 4: all inverted, PASSES=100 on the long instance
        @(negedge clk);
        long_if.start = 1'b1;
        t = cyc_free;
        @(negedge clk);
        long_if.start = 1'b0;
        lat = -1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (long_if.done) begin
                lat = cyc_free - t;
                break;
            end
        end
        chk("t4_latency", 32'(lat), 32'd1201);
        chk("t4_count",   32'(long_if.err_count), 32'd255);
        chk("t4_mask",    32'(long_if.err_mask), 32'h3F);
        chk("t4_pass",    32'(long_if.pass), 32'd0);

        // 5: start pulses while busy and during DONE are ignored
        fault_main = 0;
        start_main(t);
        repeat (4) @(negedge clk);
        main_if.start = 1'b1;
        @(negedge clk);
        main_if.start = 1'b0;
        wait_done_main(t, 13);
        main_if.start = 1'b1;
        @(negedge clk);
        main_if.start = 1'b0;
        chk("t5_no_restart", 32'(main_if.busy), 32'd0);

        // 5b: reset in the middle of vector 2
        fault_main = 3;
        start_main(t);
        repeat (6) @(negedge clk);
        chk("t5_ab_v2",     32'({main_if.a, main_if.b}), 32'd2);
        chk("t5_count_mid", 32'(main_if.err_count), 32'd12);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ab",    32'({main_if.a, main_if.b}), 32'd0);
        chk("t5_rst_busy",  32'(main_if.busy), 32'd0);
        chk("t5_rst_count", 32'(main_if.err_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_rst_nodone", 32'(main_if.done), 32'd0);
        end
        rst_n = 1'b1;
        repeat (15) @(negedge clk);

        // 6: faulty run, then a good run started the cycle after done
        fault_main = 3;
        start_main(t);
        wait_done_main(t, 13);
        chk("t6_count_faulty", 32'(main_if.err_count), 32'd24);
        fault_main = 0;
        start_main(t);
        chk("t6_clr_count", 32'(main_if.err_count), 32'd0);
        chk("t6_clr_mask",  32'(main_if.err_mask), 32'd0);
        chk("t6_clr_pass",  32'(main_if.pass), 32'd0);
        wait_done_main(t, 13);
        chk("t6_pass", 32'(main_if.pass), 32'd1);

        repeat (3) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
